// File: rtl/pipe_result_buffer_mod_counter.sv
// Wrapping up-counter: counts 0..MOD-1 and returns to 0; used as a FIFO pointer.
module mod_counter #(
   parameter int unsigned MOD = 9
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic                                   inc_i,
   output logic [((MOD > 1) ? $clog2(MOD) : 1)-1:0] value_o
);

   localparam int unsigned VW = (MOD > 1) ? $clog2(MOD) : 1;

   logic [VW-1:0] value_q;
   logic [VW-1:0] value_d;

   always_comb begin
      value_d = value_q;
      if (inc_i) begin
         value_d = (value_q == VW'(MOD - 1)) ? '0 : value_q + VW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value_o = value_q;

endmodule

// File: rtl/pipe_result_buffer.sv
// Result buffer behind a fixed-latency pipe: circular FIFO plus issue-credit counter
// so the issuer never sends more words than the buffer can hold.
module pipe_result_buffer #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 9
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         issue,
   input  logic                         in_valid,
   input  logic [WIDTH-1:0]             in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             out_data,
   output logic                         credit_ok,
   output logic [$clog2(DEPTH+1)-1:0]   credits,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy,
   output logic                         overflow
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    occupancy_q;
   logic [CW-1:0]    occupancy_d;
   logic [CW-1:0]    credits_q;
   logic [CW-1:0]    credits_d;
   logic             overflow_q;
   logic             overflow_d;
   logic             full;
   logic             pop;
   logic             push;
   logic             credit_inc;
   logic             credit_dec;

   assign full = (occupancy_q == CW'(DEPTH));
   assign pop  = out_valid && out_ready;
   // A pop frees the slot in the same cycle, so a full buffer still accepts a word.
   assign push = in_valid && (!full || pop);

   // Words already in flight across a reset come back uncredited; clamp at DEPTH.
   assign credit_dec = issue && (credits_q != '0);
   assign credit_inc = pop && (credits_q != CW'(DEPTH));

   mod_counter #(.MOD(DEPTH)) u_wr_ptr (
      .clk_i   (clock),
      .rst_i   (reset),
      .inc_i   (push),
      .value_o (wr_ptr)
   );

   mod_counter #(.MOD(DEPTH)) u_rd_ptr (
      .clk_i   (clock),
      .rst_i   (reset),
      .inc_i   (pop),
      .value_o (rd_ptr)
   );

   always_comb begin
      occupancy_d = occupancy_q;
      if (push && !pop) begin
         occupancy_d = occupancy_q + CW'(1);
      end else if (pop && !push) begin
         occupancy_d = occupancy_q - CW'(1);
      end
   end

   always_comb begin
      credits_d = credits_q;
      if (credit_inc && !credit_dec) begin
         credits_d = credits_q + CW'(1);
      end else if (credit_dec && !credit_inc) begin
         credits_d = credits_q - CW'(1);
      end
   end

   always_comb begin
      overflow_d = overflow_q;
      if ((in_valid && !push) || (issue && (credits_q == '0))) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         occupancy_q <= '0;
         credits_q   <= CW'(DEPTH);
         overflow_q  <= 1'b0;
      end else begin
         occupancy_q <= occupancy_d;
         credits_q   <= credits_d;
         overflow_q  <= overflow_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr] <= in_data;
      end
   end

   assign out_valid = (occupancy_q != '0);
   assign out_data  = mem_q[rd_ptr];
   assign credit_ok = (credits_q != '0);
   assign credits   = credits_q;
   assign occupancy = occupancy_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_pipe_result_buffer.sv
// Self-checking bench for pipe_result_buffer: scoreboard queue for data order, direct checks for counters.
module tb_pipe_result_buffer;

   localparam int unsigned W = 64;
   localparam int unsigned D = 9;

   logic          clock;
   logic          reset;
   logic          issue;
   logic          in_valid;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic          credit_ok;
   logic [3:0]    credits;
   logic [3:0]    occupancy;
   logic          overflow;

   logic [W-1:0]  sb_q [$];
   int unsigned   n_tests;
   int unsigned   n_fail;

   pipe_result_buffer #(.WIDTH(W), .DEPTH(D)) dut (
      .clock     (clock),
      .reset     (reset),
      .issue     (issue),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .credit_ok (credit_ok),
      .credits   (credits),
      .occupancy (occupancy),
      .overflow  (overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One clock cycle of stimulus; pops are checked against the scoreboard before the edge.
   task automatic cycle(input logic iss, input logic iv, input logic [W-1:0] d, input logic rdy);
      logic          pop_m;
      logic          full_m;
      logic [W-1:0]  exp;
      issue     = iss;
      in_valid  = iv;
      in_data   = d;
      out_ready = rdy;
      #1;
      n_tests++;
      if (out_valid !== (sb_q.size() != 0)) begin
         n_fail++;
         $display("FAIL out_valid: got %b expected %b", out_valid, (sb_q.size() != 0));
      end
      full_m = (sb_q.size() == D);
      pop_m  = rdy && (sb_q.size() != 0);
      if (pop_m) begin
         exp = sb_q.pop_front();
         n_tests++;
         if (out_data !== exp) begin
            n_fail++;
            $display("FAIL out_data: got %0h expected %0h", out_data, exp);
         end
      end
      if (iv && (!full_m || pop_m)) sb_q.push_back(d);
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      issue     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      sb_q.delete();
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if (occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
      n_tests++;
      if (credits !== 4'd9) begin n_fail++; $display("FAIL reset_credits: got %0d expected 9", credits); end
      n_tests++;
      if (credit_ok !== 1'b1) begin n_fail++; $display("FAIL reset_credit_ok: got %b expected 1", credit_ok); end
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_tests++;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
   endtask

   task automatic test_credits();
      do_reset();
      for (int i = 0; i < 9; i++) begin
         cycle(1'b1, 1'b0, '0, 1'b0);
         n_tests++;
         if (credits !== 4'(8 - i)) begin
            n_fail++;
            $display("FAIL credit_count: got %0d expected %0d", credits, 8 - i);
         end
      end
      n_tests++;
      if (credit_ok !== 1'b0) begin n_fail++; $display("FAIL credit_ok_zero: got %b expected 0", credit_ok); end
      n_tests++;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL credit_no_ovf: got %b expected 0", overflow); end
      cycle(1'b1, 1'b0, '0, 1'b0);
      n_tests++;
      if (overflow !== 1'b1) begin n_fail++; $display("FAIL credit_ovf: got %b expected 1", overflow); end
      n_tests++;
      if (credits !== 4'd0) begin n_fail++; $display("FAIL credit_stay0: got %0d expected 0", credits); end
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 1; i <= 9; i++) begin
         cycle(1'b1, 1'b1, W'(i), 1'b0);
         n_tests++;
         if (occupancy !== 4'(i)) begin
            n_fail++;
            $display("FAIL fill_occ: got %0d expected %0d", occupancy, i);
         end
         n_tests++;
         if (out_data !== 64'h1) begin
            n_fail++;
            $display("FAIL fill_head: got %0h expected 1", out_data);
         end
      end
      n_tests++;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_no_ovf: got %b expected 0", overflow); end
      cycle(1'b0, 1'b1, 64'hDEAD, 1'b0);
      n_tests++;
      if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_ovf: got %b expected 1", overflow); end
      n_tests++;
      if (occupancy !== 4'd9) begin n_fail++; $display("FAIL fill_drop_occ: got %0d expected 9", occupancy); end
      n_tests++;
      if (out_data !== 64'h1) begin n_fail++; $display("FAIL fill_drop_head: got %0h expected 1", out_data); end
   endtask

   task automatic test_drain();
      for (int i = 0; i < 9; i++) begin
         cycle(1'b0, 1'b0, '0, 1'b1);
         n_tests++;
         if (credits !== 4'(i + 1)) begin
            n_fail++;
            $display("FAIL drain_credits: got %0d expected %0d", credits, i + 1);
         end
      end
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b expected 0", out_valid); end
      n_tests++;
      if (occupancy !== 4'd0) begin n_fail++; $display("FAIL drain_occ: got %0d expected 0", occupancy); end
   endtask

   task automatic test_simul_push_pop();
      do_reset();
      cycle(1'b0, 1'b1, 64'h55, 1'b0);
      n_tests++;
      if (out_data !== 64'h55) begin n_fail++; $display("FAIL simul_first: got %0h expected 55", out_data); end
      cycle(1'b0, 1'b1, 64'hAA, 1'b1);
      n_tests++;
      if (occupancy !== 4'd1) begin n_fail++; $display("FAIL simul_occ: got %0d expected 1", occupancy); end
      n_tests++;
      if (out_data !== 64'hAA) begin n_fail++; $display("FAIL simul_data: got %0h expected aa", out_data); end
      cycle(1'b0, 1'b0, '0, 1'b1);
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, W'(32'h100 + i), 1'b1);
      cycle(1'b0, 1'b0, '0, 1'b1);
      n_tests++;
      if (sb_q.size() != 0 || occupancy !== 4'd0) begin
         n_fail++;
         $display("FAIL wrap_drain: got occ %0d expected 0", occupancy);
      end
      n_tests++;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf: got %b expected 0", overflow); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, W'(32'h200 + i), 1'b0);
      n_tests++;
      if (occupancy !== 4'd5) begin n_fail++; $display("FAIL mid_occ5: got %0d expected 5", occupancy); end
      n_tests++;
      if (credits !== 4'd4) begin n_fail++; $display("FAIL mid_credits4: got %0d expected 4", credits); end
      do_reset();
      n_tests++;
      if (occupancy !== 4'd0) begin n_fail++; $display("FAIL mid_occ0: got %0d expected 0", occupancy); end
      n_tests++;
      if (credits !== 4'd9) begin n_fail++; $display("FAIL mid_credits9: got %0d expected 9", credits); end
      n_tests++;
      if (out_valid !== 1'b0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_flags: got valid %b ovf %b expected 0 0", out_valid, overflow);
      end
      cycle(1'b0, 1'b1, 64'h300, 1'b0);
      n_tests++;
      if (occupancy !== 4'd1) begin n_fail++; $display("FAIL inflight_occ: got %0d expected 1", occupancy); end
      cycle(1'b0, 1'b0, '0, 1'b1);
      n_tests++;
      if (credits !== 4'd9) begin n_fail++; $display("FAIL inflight_clamp: got %0d expected 9", credits); end
      n_tests++;
      if (occupancy !== 4'd0) begin n_fail++; $display("FAIL inflight_pop: got %0d expected 0", occupancy); end
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      reset     = 1'b1;
      issue     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      @(posedge clock);
      #1;
      test_reset();
      test_credits();
      test_fill();
      test_drain();
      test_simul_push_pop();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_result_buffer.md
PIPE_RESULT_BUFFER -- requirements
Module: pipe_result_buffer

Interface
REQ-001 Parameter WIDTH, default 64: data width of each result word.
REQ-002 Parameter DEPTH, default 9: buffer entries and total issue credits; matches the default clock_delay stage count.
REQ-003 clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 issue  input  1  issuer injects one word into the fixed-latency delay line this cycle.
REQ-006 in_valid  input  1  a delayed word arrives from the delay line this cycle.
REQ-007 in_data  input  WIDTH  arriving word; sampled only when in_valid=1.
REQ-008 out_valid  output  1  head word available to the consumer.
REQ-009 out_ready  input  1  consumer accepts the head word; a pop occurs when out_valid & out_ready.
REQ-010 out_data  output  WIDTH  head word; held stable while out_valid=1 and out_ready=0.
REQ-011 credit_ok  output  1  the issuer may assert issue this cycle (credits > 0).
REQ-012 credits  output  $clog2(DEPTH+1)  free credits.
REQ-013 occupancy  output  $clog2(DEPTH+1)  words held in the buffer.
REQ-014 overflow  output  1  sticky error flag.

Function
REQ-015 Buffer: circular FIFO of DEPTH words with read and write pointers; each pointer wraps from DEPTH-1 to 0 (DEPTH need not be a power of 2).
REQ-016 Write: in_valid=1 and occupancy<DEPTH -> write in_data at the write pointer; pointer advances; occupancy +1.
REQ-017 Read: a pop advances the read pointer; occupancy -1.
REQ-018 Push and pop in the same cycle -> both occur; occupancy is unchanged; legal when full and when occupancy=1.
REQ-019 No bypass: a word written into an empty buffer appears on out_valid/out_data the following cycle (latency 1).
REQ-020 out_valid = (occupancy != 0); out_data = entry at the read pointer.
REQ-021 Full with in_valid=1 and no pop -> word dropped; overflow set; pointers and occupancy unchanged.
REQ-022 Credits: issue with credits>0 -> credits -1; pop -> credits +1; both in the same cycle -> unchanged.
REQ-023 Issue with credits=0 -> credits stay 0; overflow set.
REQ-024 Credit range: credits never exceeds DEPTH; credits + in-flight + occupancy = DEPTH at every cycle boundary.
REQ-025 credit_ok = (credits != 0), combinational from the credits register.
REQ-026 overflow remains set until reset.

Reset
REQ-027 While reset=1 at a rising edge: pointers=0, occupancy=0, credits=DEPTH, overflow=0; hence out_valid=0 and credit_ok=1 on the next cycle.
REQ-028 Reset mid-operation discards all buffered words; in-flight words that arrive after reset are written normally and are not credited.
REQ-029 Buffer storage is not reset; out_data is don't-care while out_valid=0.

Structure
REQ-030 No shared-package content: WIDTH and DEPTH are module parameters only, with no typedefs.
REQ-031 Pointer-increment-with-wrap is the natural sub-module: mod_counter (parameter MOD), instantiated twice.
REQ-032 Storage is a register array inside pipe_result_buffer; the credit counter is inline.

Verification
REQ-033 Reset, then issue 9 words on consecutive cycles -> credits 9→0 and credit_ok=0 after the 9th; a 10th issue sets overflow=1 and credits stay 0.
REQ-034 Words 0x1..0x9 arrive via in_valid with out_ready=0 -> occupancy=9; out_data=0x1 held stable; a further in_valid sets overflow and the word is dropped.
REQ-035 Full buffer, out_ready=1 for 9 cycles -> outputs 0x1..0x9 in order; credits return to 9; out_valid=0 afterwards.
REQ-036 Occupancy 1, push 0xAA with a simultaneous pop -> occupancy stays 1; out_data=0xAA next cycle.
REQ-037 Push 20 words with continuous pops -> in-order output across pointer wrap (8→0); overflow stays 0.
REQ-038 Reset asserted at occupancy 5 -> next cycle occupancy=0, credits=9, overflow=0, out_valid=0.
